microsequencer_stack: RTL
=========================

// Module: microsequencer_stack
// PURPOSE
//  Parametrised microprogram sequencer for the matrix-multiply core controller; successor to the fixed 16-bit inc/jump/map sequencer.
//  Adds a conditional-branch mux over NCOND flags, a CALL/RET micro-stack, start/busy/done handshake, a stall hold, and error halting.
//  Drives an external async-read microcode ROM (upc -> uword), then decodes sequencing fields and emits the control field to the datapath.
// PARAMETERS
//  AW      7   micro-PC / jump address width
//  CTRL_W  51  control-op field width (ops output)
//  IR_W    16  instruction register width
//  OPC_W   4   opcode bits IR[IR_W-1 -: OPC_W] used by the map function
//  MAP_SH  3   map address = MAP_BASE + (opcode << MAP_SH), truncated to AW
//  MAP_BASE 8  base of the dispatch table
//  NCOND   4   condition inputs; CSW = max(1,$clog2(NCOND))
//  DEPTH   4   micro-stack entries (>=1)
// PORTS
//  clk      in   1           rising-edge clock
//  reset_n  in   1           asynchronous active-low reset
//  start    in   1           begin execution of ir; accepted only in IDLE
//  ir       in   IR_W        instruction, sampled on accepted start
//  cond     in   NCOND       status flags (cond[0] = z)
//  stall    in   1           hold micro-PC and suppress ops this cycle
//  upc      out  AW          micro-PC to microcode ROM
//  uword    in   UW          ROM word, UW = CTRL_W+AW+CSW+4
//  ops      out  CTRL_W      control ops to datapath
//  busy     out  1           high in RUN
//  done     out  1           one-cycle pulse on HALT retirement
//  err      out  1           sticky stack fault; cleared by accepted start
// BEHAVIOUR
//  uword layout MSB->LSB: seq[2:0] | pol | csel[CSW-1:0] | jaddr[AW-1:0] | ctrl[CTRL_W-1:0].
//  seq: 0 INC, 1 JMP, 2 JCOND, 3 MAP, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as INC).
//  cond_true = cond[csel] ^ pol; csel >= NCOND reads 0.
//  Reset (async, reset_n=0): state=IDLE, upc=0, sp=0, ir_q=0, ops=0, busy=0, done=0, err=0.
//  FSM IDLE -> RUN on start (ir_q<=ir, upc<=map(ir), err<=0); start ignored in RUN.
//  RUN, stall=1: upc, sp, and stack hold; ops=0; no state change.
//  RUN, stall=0: ops=ctrl (combinational from uword); next upc per seq:
//    INC upc+1 (wraps mod 2^AW); JMP jaddr; JCOND cond_true?jaddr:upc+1;
//    MAP map(ir_q); CALL push upc+1, upc<=jaddr; RET upc<=pop;
//    HALT -> IDLE, done=1 for exactly that one cycle, ops still = ctrl that cycle.
//  Fault: CALL with sp==DEPTH or RET with sp==0 -> err<=1, no push/pop, -> IDLE, done=1.
//  In IDLE: ops=0, busy=0, upc holds last value.
//  Latency: start-to-first-op is 1 cycle (first op in cycle after start); 1 microword per unstalled cycle.
//  Reset asserted mid-RUN aborts immediately; no done pulse; stack contents discarded (sp=0).
//  All address arithmetic is AW-bit unsigned and wraps; no overflow flag.
// TESTING
//  1 Reset mid-run: reset_n low in RUN -> next edge-free sample ops=0, busy=0, upc=0, sp=0.
//  2 Map/INC/HALT: ir=16'h3000 -> upc=8+(3<<3)=32; ROM 32 INC, 33 HALT -> ops seq ctrl32, ctrl33; done pulses 2 cycles after start.
//  3 JCOND: csel=0, pol=0, jaddr=50 at upc 40; cond=4'b0001 -> upc=50; cond=0 -> 41; pol=1 inverts both.
//  4 CALL/RET nesting: DEPTH=4, four nested CALLs then four RETs -> return to each upc+1 in LIFO order; err=0.
//  5 Stack faults: fifth CALL -> err=1, done=1, IDLE; RET at sp=0 -> same; next start clears err.
//  6 Stall and ignored start: stall=1 for 3 cycles at upc 33 -> upc holds, ops=0; start pulsed in RUN -> ir_q unchanged.

Source files
------------

// File: rtl/microsequencer_stack.sv
// microsequencer_stack
//   Microprogram sequencer for the matrix-multiply core controller. Drives an
//   external async-read microcode ROM, decodes its sequencing fields and forwards
//   the control field to the datapath. Supports conditional branches over NCOND
//   flags, a CALL/RET micro-stack, a start/busy/done handshake, stall, and error halt.
// Ports
//   clk, reset_n  clock / async active-low reset
//   start, ir     begin executing ir (accepted only while idle)
//   cond          status flags for JCOND (cond[0] = z)
//   stall         hold micro-PC and suppress ops this cycle
//   upc, uword    ROM address out / ROM word in
//   ops           control ops to datapath (0 when idle or stalled)
//   busy, done    running / one-cycle retirement pulse (HALT or fault)
//   err           sticky stack fault, cleared by an accepted start
module microsequencer_stack #(
  parameter int AW       = 7,
  parameter int CTRL_W   = 51,
  parameter int IR_W     = 16,
  parameter int OPC_W    = 4,
  parameter int MAP_SH   = 3,
  parameter int MAP_BASE = 8,
  parameter int NCOND    = 4,
  parameter int DEPTH    = 4,
  localparam int CSW     = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int UW      = CTRL_W + AW + CSW + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IR_W-1:0]   ir,
  input  logic [NCOND-1:0]  cond,
  input  logic              stall,
  output logic [AW-1:0]     upc,
  input  logic [UW-1:0]     uword,
  output logic [CTRL_W-1:0] ops,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NSLOT = 1 << IW;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    SQ_INC, SQ_JMP, SQ_JCOND, SQ_MAP, SQ_CALL, SQ_RET, SQ_HALT, SQ_RSV
  } seq_t;

  typedef struct packed {
    logic [2:0]        seq;
    logic              pol;
    logic [CSW-1:0]    csel;
    logic [AW-1:0]     jaddr;
    logic [CTRL_W-1:0] ctrl;
  } uword_t;

  uword_t                  uw;
  seq_t                    seq;
  state_t                  state, state_nx;
  logic [AW-1:0]           upc_nx, upc_inc;
  logic [SPW-1:0]          sp, sp_nx;
  logic [NSLOT-1:0][AW-1:0] stk;
  logic                    push;
  logic [IR_W-1:0]         ir_q;
  logic                    ld_ir;
  logic                    err_nx;
  logic [(1<<CSW)-1:0]     cond_x;
  logic                    cond_true;
  logic [IW-1:0]           wr_idx, rd_idx;
  logic                    unused_ir;

  function automatic logic [AW-1:0] map_addr(input logic [IR_W-1:0] i);
    return AW'(MAP_BASE + (int'(i[IR_W-1 -: OPC_W]) << MAP_SH));
  endfunction

  assign uw        = uword;
  assign seq       = seq_t'(uw.seq);
  assign upc_inc   = upc + AW'(1);
  // Push slot is the current sp; pop slot is the entry just below it.
  assign wr_idx    = sp[IW-1:0];
  assign rd_idx    = IW'(sp - SPW'(1));
  assign unused_ir = ^ir_q[IR_W-OPC_W-1:0];

  // Zero-extend so selectors past NCOND read 0.
  always_comb begin
    cond_x = '0;
    cond_x[NCOND-1:0] = cond;
  end
  assign cond_true = cond_x[uw.csel] ^ uw.pol;

  always_comb begin
    state_nx = state;
    upc_nx   = upc;
    sp_nx    = sp;
    push     = 1'b0;
    ld_ir    = 1'b0;
    err_nx   = err;
    ops      = '0;
    done     = 1'b0;
    busy     = (state == RUN);
    case (state)
      IDLE: if (start) begin
        state_nx = RUN;
        ld_ir    = 1'b1;
        upc_nx   = map_addr(ir);
        err_nx   = 1'b0;
      end
      RUN: if (!stall) begin
        ops = uw.ctrl;
        case (seq)
          SQ_JMP:   upc_nx = uw.jaddr;
          SQ_JCOND: upc_nx = cond_true ? uw.jaddr : upc_inc;
          SQ_MAP:   upc_nx = map_addr(ir_q);
          SQ_CALL: begin
            if (sp == SPW'(DEPTH)) begin
              err_nx = 1'b1; state_nx = IDLE; done = 1'b1;
            end else begin
              push = 1'b1; sp_nx = sp + SPW'(1); upc_nx = uw.jaddr;
            end
          end
          SQ_RET: begin
            if (sp == '0) begin
              err_nx = 1'b1; state_nx = IDLE; done = 1'b1;
            end else begin
              sp_nx = sp - SPW'(1); upc_nx = stk[rd_idx];
            end
          end
          SQ_HALT: begin
            state_nx = IDLE; done = 1'b1;
          end
          default:  upc_nx = upc_inc;  // INC and reserved
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      upc   <= '0;
      sp    <= '0;
      stk   <= '0;
      ir_q  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      upc   <= upc_nx;
      sp    <= sp_nx;
      err   <= err_nx;
      if (ld_ir) ir_q <= ir;
      if (push)  stk[wr_idx] <= upc_inc;
    end
  end

endmodule
